// File: rtl/prirv32_pkg.sv
// Shared definitions for the prirv32 load/store unit: op-bit positions,
// FSM encoding, byte-strobe constants and the multi-hot op resolver.
package prirv32_pkg;

    localparam int OP_LB  = 7;
    localparam int OP_LH  = 6;
    localparam int OP_LW  = 5;
    localparam int OP_LBU = 4;
    localparam int OP_LHU = 3;
    localparam int OP_SB  = 2;
    localparam int OP_SH  = 1;
    localparam int OP_SW  = 0;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // Reduce a possibly multi-hot op to one-hot; the highest bit (lb) wins.
    function automatic logic [7:0] op_pick(input logic [7:0] op);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            if (op[i]) res = 8'(1) << i;
        end
        return res;
    endfunction

endpackage

// File: rtl/prirv32_lsu_align.sv
// Byte-lane logic: store strobes and lane replication, load lane select
// with sign/zero extension, and size-based misalignment detection.
module prirv32_lsu_align
    import prirv32_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata_i[{addr_i, 3'b000} +: 8];
    assign lane_h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        wstrb_o    = 4'b0000;
        wdata_o    = wdata_i;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        if (op_i[OP_LB]) begin
            rdata_o = {{24{lane_b[7]}}, lane_b};
        end else if (op_i[OP_LH]) begin
            rdata_o    = {{16{lane_h[15]}}, lane_h};
            misalign_o = addr_i[0];
        end else if (op_i[OP_LW]) begin
            rdata_o    = rdata_i;
            misalign_o = |addr_i;
        end else if (op_i[OP_LBU]) begin
            rdata_o = {24'h0, lane_b};
        end else if (op_i[OP_LHU]) begin
            rdata_o    = {16'h0, lane_h};
            misalign_o = addr_i[0];
        end else if (op_i[OP_SB]) begin
            wstrb_o = STRB_B << addr_i;
            wdata_o = {4{wdata_i[7:0]}};
        end else if (op_i[OP_SH]) begin
            wstrb_o    = STRB_H << {addr_i[1], 1'b0};
            wdata_o    = {2{wdata_i[15:0]}};
            misalign_o = addr_i[0];
        end else if (op_i[OP_SW]) begin
            wstrb_o    = STRB_W;
            misalign_o = |addr_i;
        end
    end

endmodule

// File: rtl/prirv32_lsu.sv
// Load/store unit: one aligned 32-bit bus access per request, bus-wait
// timeout, and a registered writeback packet on a valid/ready handshake.
module prirv32_lsu
    import prirv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_we,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_misalign,
    output logic        resp_fault,
    output logic [31:0] resp_addr,
    output lsu_state_e  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the initiator holds its payload stable while valid is high and not ready.
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q;
    logic [7:0]       op_q;
    logic [1:0]       addr_lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_valid_q, resp_valid_q, resp_we_q, resp_mis_q, resp_fault_q;
    logic [31:0]      mem_addr_q, mem_wdata_q, resp_data_q, resp_addr_q;
    logic [3:0]       mem_wstrb_q;
    logic [4:0]       resp_rd_q;

    logic [7:0]  req_op_1h, al_op;
    logic [1:0]  al_addr;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, al_rdata;
    logic        al_misalign;

    assign req_op_1h = op_pick(req_op);
    // The aligner serves the request in IDLE and the latched op during BUS.
    assign al_op     = (state_q == ST_IDLE) ? req_op_1h : op_q;
    assign al_addr   = (state_q == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

    prirv32_lsu_align u_align (
        .op_i       (al_op),
        .addr_i     (al_addr),
        .wdata_i    (req_wdata),
        .rdata_i    (mem_rdata),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            addr_lo_q    <= '0;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_rd_q    <= '0;
            resp_data_q  <= '0;
            resp_mis_q   <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q         <= req_op_1h;
                        addr_lo_q    <= req_addr[1:0];
                        resp_rd_q    <= req_rd;
                        resp_addr_q  <= req_addr;
                        resp_data_q  <= '0;
                        resp_we_q    <= 1'b0;
                        resp_fault_q <= 1'b0;
                        resp_mis_q   <= al_misalign;
                        if (al_misalign || (req_op_1h == 8'h00)) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q     <= ST_BUS;
                            cnt_q       <= '0;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_wdata_q <= al_wdata;
                            mem_wstrb_q <= al_wstrb;
                        end
                    end
                end
                ST_BUS: begin
                    if (mem_ready) begin
                        state_q      <= ST_RESP;
                        mem_valid_q  <= 1'b0;
                        mem_wstrb_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= al_rdata;
                        resp_we_q    <= (|op_q[7:3]) && (resp_rd_q != 5'd0);
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        state_q      <= ST_RESP;
                        mem_valid_q  <= 1'b0;
                        mem_wstrb_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = (state_q == ST_IDLE) && !rst_in;
    assign mem_valid     = mem_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign resp_valid    = resp_valid_q;
    assign resp_we       = resp_we_q;
    assign resp_rd       = resp_rd_q;
    assign resp_data     = resp_data_q;
    assign resp_misalign = resp_mis_q;
    assign resp_fault    = resp_fault_q;
    assign resp_addr     = resp_addr_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_prirv32_lsu.sv
// Self-checking bench for prirv32_lsu with a 4-cycle bus timeout.
module tb_prirv32_lsu;
    import prirv32_pkg::*;

    localparam int RW = 72;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_misalign, resp_fault;
    logic [31:0] resp_addr;
    lsu_state_e  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [RW-1:0] exp_q[$];

    always #5 clk_in = ~clk_in;

    prirv32_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
        .resp_rd(resp_rd), .resp_data(resp_data), .resp_misalign(resp_misalign),
        .resp_fault(resp_fault), .resp_addr(resp_addr), .dbg_state(dbg_state)
    );

    function automatic logic [RW-1:0] pack(input logic [31:0] addr, input logic [31:0] data,
                                           input logic [4:0] rd, input logic we,
                                           input logic mis, input logic fault);
        return {addr, data, rd, we, mis, fault};
    endfunction

    function automatic logic [RW-1:0] cur_resp();
        return {resp_addr, resp_data, resp_rd, resp_we, resp_misalign, resp_fault};
    endfunction

    // Independent load model: pick the lane by shifting, extend via signed casts.
    function automatic logic [31:0] model_load(input int idx, input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] w;
        w = rd >> (8 * a);
        case (idx)
            7: return 32'($signed(w[7:0]));
            6: return 32'($signed(w[15:0]));
            5: return rd;
            4: return {24'h0, w[7:0]};
            3: return {16'h0, w[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
        req_op    = '0;
    endtask

    task automatic bus_do(input int waits, input logic [31:0] rdata);
        repeat (waits) tick();
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic get_resp(output logic [RW-1:0] obs, output int waited, output bit saw_mem);
        waited  = 0;
        saw_mem = 1'b0;
        while (!resp_valid && waited < 50) begin
            if (mem_valid) saw_mem = 1'b1;
            tick();
            waited++;
        end
        if (mem_valid) saw_mem = 1'b1;
        obs = resp_valid ? cur_resp() : 'x;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_ready: got %b required 0", req_ready);
        end
        checks++;
        if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got %b/%h/%h/%b required zero", mem_valid, mem_addr, mem_wdata, mem_wstrb);
        end
        checks++;
        if ({resp_valid, cur_resp()} !== '0) begin
            errors++;
            $display("FAIL reset_resp: got valid=%b pkt=%h required zero", resp_valid, cur_resp());
        end
        rst_in = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_release: req_ready=%b state=%0d required 1/IDLE", req_ready, dbg_state);
        end
    endtask

    task automatic test_store_word();
        logic [RW-1:0] obs, exp;
        int waited;
        bit saw;
        send(8'h01, 32'h100, 32'hDEADBEEF, 5'd3);
        exp_q.push_back(pack(32'h100, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0));
        checks++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h100, 4'b1111, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL sw_bus: got %b/%h/%b/%h required 1/00000100/1111/deadbeef",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata);
        end
        bus_do(0, 32'h0);
        get_resp(obs, waited, saw);
        exp = exp_q.pop_front();
        checks++;
        if (waited !== 0) begin
            errors++;
            $display("FAIL sw_latency: resp_valid after %0d extra cycles required 0", waited);
        end
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sw_resp: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_load_byte();
        logic [RW-1:0] obs, exp;
        int waited;
        bit saw;
        logic [7:0] ops [2];
        logic [31:0] res [2];
        ops[0] = 8'h80; res[0] = 32'hFFFFFF80;
        ops[1] = 8'h10; res[1] = 32'h00000080;
        for (int i = 0; i < 2; i++) begin
            send(ops[i], 32'h203, 32'h0, 5'd5);
            exp_q.push_back(pack(32'h203, res[i], 5'd5, 1'b1, 1'b0, 1'b0));
            checks++;
            if ({mem_valid, mem_addr, mem_wstrb} !== {1'b1, 32'h200, 4'b0000}) begin
                errors++;
                $display("FAIL lb_bus[%0d]: got %b/%h/%b required 1/00000200/0000", i, mem_valid, mem_addr, mem_wstrb);
            end
            bus_do(0, 32'h80FF1234);
            get_resp(obs, waited, saw);
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lb_resp[%0d]: got %h required %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_half();
        logic [RW-1:0] obs, exp;
        int waited;
        bit saw;
        send(8'h02, 32'h302, 32'h0000ABCD, 5'd2);
        exp_q.push_back(pack(32'h302, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0));
        checks++;
        if ({mem_wstrb, mem_wdata, mem_addr} !== {4'b1100, 32'hABCDABCD, 32'h300}) begin
            errors++;
            $display("FAIL sh_bus: got %b/%h/%h required 1100/abcdabcd/00000300", mem_wstrb, mem_wdata, mem_addr);
        end
        bus_do(1, 32'h0);
        get_resp(obs, waited, saw);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL sh_resp: got %h required %h", obs, exp);
        end
        send(8'h40, 32'h302, 32'h0, 5'd7);
        exp_q.push_back(pack(32'h302, 32'h00007FFF, 5'd7, 1'b1, 1'b0, 1'b0));
        bus_do(0, 32'h7FFF0000);
        get_resp(obs, waited, saw);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL lh_resp: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_special_ops();
        logic [RW-1:0] obs, exp;
        int waited;
        bit saw;
        send(8'h20, 32'h401, 32'h0, 5'd9);
        exp_q.push_back(pack(32'h401, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0));
        get_resp(obs, waited, saw);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp || saw || mem_valid) begin
            errors++;
            $display("FAIL lw_misalign: got %h mem_seen=%b required %h mem_seen=0", obs, saw, exp);
        end
        send(8'h20, 32'h404, 32'h0, 5'd0);
        exp_q.push_back(pack(32'h404, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b0));
        bus_do(0, 32'h12345678);
        get_resp(obs, waited, saw);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL lw_rd0: got %h required %h", obs, exp);
        end
        send(8'h00, 32'h7, 32'h55, 5'd8);
        exp_q.push_back(pack(32'h7, 32'h0, 5'd8, 1'b0, 1'b0, 1'b0));
        get_resp(obs, waited, saw);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp || saw) begin
            errors++;
            $display("FAIL zero_hot: got %h mem_seen=%b required %h mem_seen=0", obs, saw, exp);
        end
        // lb and lh both set: lb wins, so the odd address is not misaligned
        send(8'hC0, 32'h203, 32'h0, 5'd6);
        exp_q.push_back(pack(32'h203, 32'hFFFFFF80, 5'd6, 1'b1, 1'b0, 1'b0));
        bus_do(0, 32'h80FF1234);
        get_resp(obs, waited, saw);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL multi_hot: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_timeout();
        logic [RW-1:0] obs, exp;
        int waited, cnt;
        bit saw;
        send(8'h20, 32'h500, 32'h0, 5'd4);
        exp_q.push_back(pack(32'h500, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1));
        cnt = 0;
        while (mem_valid && cnt < 20) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== 4) begin
            errors++;
            $display("FAIL timeout_len: mem_valid cycles=%0d required 4", cnt);
        end
        get_resp(obs, waited, saw);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL timeout_resp: got %h required %h", obs, exp);
        end
        send(8'h20, 32'h504, 32'h0, 5'd4);
        exp_q.push_back(pack(32'h504, 32'hCAFEF00D, 5'd4, 1'b1, 1'b0, 1'b0));
        bus_do(3, 32'hCAFEF00D);
        get_resp(obs, waited, saw);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp || waited !== 0) begin
            errors++;
            $display("FAIL timeout_race: got %h wait=%0d required %h wait=0", obs, waited, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] obs, exp, snap;
        int waited;
        bit saw;
        send(8'h01, 32'h700, 32'h11223344, 5'd1);
        exp_q.push_back(pack(32'h700, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0));
        bus_do(1, 32'h0);
        snap = cur_resp();
        req_valid = 1'b1;
        req_op    = 8'h80;
        req_addr  = 32'h999;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cur_resp() !== snap || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: pkt=%h valid=%b req_ready=%b required %h/1/0",
                         i, cur_resp(), resp_valid, req_ready, snap);
            end
        end
        req_valid = 1'b0;
        req_op    = '0;
        get_resp(obs, waited, saw);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL hold_resp: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_random();
        logic [RW-1:0] obs, exp;
        int waited, idx, w;
        bit saw;
        logic [31:0] addr, wdata, rdata, exp_wd;
        logic [3:0]  exp_st;
        logic [4:0]  rd;
        for (int n = 0; n < 24; n++) begin
            idx   = $urandom_range(0, 7);
            addr  = $urandom();
            wdata = $urandom();
            rdata = $urandom();
            rd    = 5'($urandom_range(0, 31));
            w     = $urandom_range(0, 2);
            if (idx == 6 || idx == 3 || idx == 1) addr[0] = 1'b0;
            if (idx == 5 || idx == 0) addr[1:0] = 2'b00;
            case (idx)
                2: begin exp_st = 4'b0001 << addr[1:0]; exp_wd = {4{wdata[7:0]}}; end
                1: begin exp_st = addr[1] ? 4'b1100 : 4'b0011; exp_wd = {2{wdata[15:0]}}; end
                0: begin exp_st = 4'b1111; exp_wd = wdata; end
                default: begin exp_st = 4'b0000; exp_wd = 32'h0; end
            endcase
            send(8'(1) << idx, addr, wdata, rd);
            exp_q.push_back(pack(addr, model_load(idx, addr[1:0], rdata), rd,
                                 (idx >= 3) && (rd != 5'd0), 1'b0, 1'b0));
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== {addr[31:2], 2'b00} || mem_wstrb !== exp_st
                || (idx <= 2 && mem_wdata !== exp_wd)) begin
                errors++;
                $display("FAIL rand_bus[%0d]: op=%0d got %h/%b/%h required %h/%b/%h",
                         n, idx, mem_addr, mem_wstrb, mem_wdata, {addr[31:2], 2'b00}, exp_st, exp_wd);
            end
            bus_do(w, rdata);
            get_resp(obs, waited, saw);
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rand_resp[%0d]: op=%0d got %h required %h", n, idx, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        send(8'h20, 32'h600, 32'h0, 5'd3);
        rst_in = 1'b1;
        tick();
        checks++;
        if (mem_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid: mem_valid=%b state=%0d required 0/IDLE", mem_valid, dbg_state);
        end
        rst_in    = 1'b0;
        mem_ready = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid || mem_valid) seen = 1'b1;
        end
        mem_ready = 1'b0;
        checks++;
        if (seen || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_quiet: activity=%b req_ready=%b required 0/1", seen, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_half();
        test_special_ops();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
